// File: rtl/sprite_draw_arbiter_pkg.sv
// Shared types and constants for the sprite draw arbiter slice.
// Holds FSM states, default sprite size and VGA coordinate widths.
package draw_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  localparam int SPR_W_LOG2_DEF = 1;
  localparam int SPR_H_LOG2_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sprite_draw_arbiter_if.sv
// Requester-side bus of the sprite draw arbiter.
// Ports: req, req_x/y/colour (flattened per requester), ack, grant.
interface sprite_draw_arbiter_if
  import draw_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]     req;
  logic [X_W*NUM_REQ-1:0] req_x;
  logic [Y_W*NUM_REQ-1:0] req_y;
  logic [C_W*NUM_REQ-1:0] req_colour;
  logic [NUM_REQ-1:0]     ack;
  logic [NUM_REQ-1:0]     grant;

  modport master (
    output req, req_x, req_y, req_colour,
    input  ack, grant
  );

  modport slave (
    input  req, req_x, req_y, req_colour,
    output ack, grant
  );

endinterface

// File: rtl/sprite_draw_arbiter_req_arbiter.sv
// Winner select: req vector + rotate pointer in, one-hot winner out.
// ROUND_ROBIN_EN picks from the pointer onward; else lowest index.
module req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner
);

`ifdef ROUND_ROBIN_EN
  always_comb begin
    logic found;
    int   idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/sprite_draw_arbiter.sv
// Shares one VGA plot port between NUM_REQ sprite datapaths.
// Ports: clock, resetn, bus (slave), plot, x_out, y_out, colour_out,
// busy. Macro ROUND_ROBIN_EN selects rotating priority.
module sprite_draw_arbiter
  import draw_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int SPR_W_LOG2 = SPR_W_LOG2_DEF,
  parameter int SPR_H_LOG2 = SPR_H_LOG2_DEF
) (
  input  logic                 clock,
  input  logic                 resetn,
  sprite_draw_arbiter_if.slave bus,
  output logic                 plot,
  output logic [X_W-1:0]       x_out,
  output logic [Y_W-1:0]       y_out,
  output logic [C_W-1:0]       colour_out,
  output logic                 busy
);

  localparam int CNT_W = SPR_W_LOG2 + SPR_H_LOG2;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nx;
  logic [X_W-1:0]     base_x;
  logic [Y_W-1:0]     base_y;
  logic [C_W-1:0]     base_c;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] win;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   ptr;
  logic [X_W-1:0]     sel_x;
  logic [Y_W-1:0]     sel_y;
  logic [C_W-1:0]     sel_c;
  logic [X_W-1:0]     x_off;
  logic [Y_W-1:0]     y_off;

  assign bus.grant = grant_q;
  assign bus.ack   = ack_q;

  req_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .winner(win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win[i]) win_idx = PTR_W'(i);
  end

  assign sel_x = bus.req_x[win_idx*X_W +: X_W];
  assign sel_y = bus.req_y[win_idx*Y_W +: Y_W];
  assign sel_c = bus.req_colour[win_idx*C_W +: C_W];

  // Outputs are registered, so the address of the *next* count is
  // computed here; high count bits step x (column-major walk).
  assign cnt_nx = cnt + CNT_W'(1);
  assign x_off  = X_W'(cnt_nx[CNT_W-1:SPR_H_LOG2]);
  assign y_off  = Y_W'(cnt_nx[SPR_H_LOG2-1:0]);

`ifdef ROUND_ROBIN_EN
  logic [PTR_W-1:0] gnt_idx;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_q[i]) gnt_idx = PTR_W'(i);
  end

  always_ff @(posedge clock) begin
    if (!resetn)
      ptr <= '0;
    else if (state == DONE)
      ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1))
           ? '0 : gnt_idx + PTR_W'(1);
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      grant_q    <= '0;
      ack_q      <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
      base_x     <= '0;
      base_y     <= '0;
      base_c     <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            state      <= DRAW;
            grant_q    <= win;
            base_x     <= sel_x;
            base_y     <= sel_y;
            base_c     <= sel_c;
            cnt        <= '0;
            plot       <= 1'b1;
            busy       <= 1'b1;
            x_out      <= sel_x;
            y_out      <= sel_y;
            colour_out <= sel_c;
          end
        end
        DRAW: begin
          if (&cnt) begin
            state      <= DONE;
            plot       <= 1'b0;
            ack_q      <= grant_q;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
          end else begin
            cnt        <= cnt_nx;
            x_out      <= base_x + x_off;
            y_out      <= base_y + y_off;
            colour_out <= base_c;
          end
        end
        DONE: begin
          state   <= IDLE;
          ack_q   <= '0;
          grant_q <= '0;
          busy    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Scoreboard bench for sprite_draw_arbiter: random requests,
// mid-draw perturbation and reset, checked against a pixel model.
module tb_sprite_draw_arbiter;
  import draw_pkg::*;

  localparam int N    = 4;
  localparam int NPIX = 32;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  sprite_draw_arbiter_if #(.NUM_REQ(N)) bus ();

  logic           plot;
  logic           busy;
  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic [C_W-1:0] colour_out;

  sprite_draw_arbiter #(
    .NUM_REQ   (N),
    .SPR_W_LOG2(1),
    .SPR_H_LOG2(4)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .bus       (bus),
    .plot      (plot),
    .x_out     (x_out),
    .y_out     (y_out),
    .colour_out(colour_out),
    .busy      (busy)
  );

  typedef struct {
    bit is_ack;
    int g;
    int x;
    int y;
    int c;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  logic [N-1:0] rq;
  int mx[N];
  int my[N];
  int mc[N];
  int ptr_m = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, req);
    end
  endtask

  task automatic apply();
    bus.req = rq;
    for (int i = 0; i < N; i++) begin
      bus.req_x[i*X_W +: X_W]      = X_W'(mx[i]);
      bus.req_y[i*Y_W +: Y_W]      = Y_W'(my[i]);
      bus.req_colour[i*C_W +: C_W] = C_W'(mc[i]);
    end
  endtask

  task automatic new_req(input int i);
    rq[i] = 1'b1;
    mx[i] = int'($urandom_range(0, 255));
    my[i] = int'($urandom_range(0, 127));
    mc[i] = int'($urandom_range(0, 7));
  endtask

  function automatic int pick();
    int r;
    r = -1;
`ifdef ROUND_ROBIN_EN
    for (int k = N - 1; k >= 0; k--)
      if (rq[(ptr_m + k) % N]) r = (ptr_m + k) % N;
`else
    for (int k = N - 1; k >= 0; k--)
      if (rq[k]) r = k;
`endif
    return r;
  endfunction

  // Monitor: every plot or ack cycle consumes one expectation.
  always @(negedge clock) begin
    exp_t e;
    if (resetn) begin
      if (plot || bus.ack != '0) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          if (plot) begin
            chk("kind_pix", 32'(e.is_ack), 32'd0);
            chk("x_out", 32'(x_out), 32'(e.x));
            chk("y_out", 32'(y_out), 32'(e.y));
            chk("colour", 32'(colour_out), 32'(e.c));
            chk("grant_draw", 32'(bus.grant), 32'(1 << e.g));
            chk("busy_draw", 32'(busy), 32'd1);
            chk("ack_draw", 32'(bus.ack), 32'd0);
          end else begin
            chk("kind_ack", 32'(e.is_ack), 32'd1);
            chk("ack", 32'(bus.ack), 32'(1 << e.g));
            chk("grant_done", 32'(bus.grant), 32'(1 << e.g));
            chk("xyc_done", 32'({x_out, y_out, colour_out}), 32'd0);
          end
        end
      end else begin
        chk("xyc_idle", 32'({x_out, y_out, colour_out}), 32'd0);
        if (!busy) chk("grant_idle", 32'(bus.grant), 32'd0);
      end
    end
  end

  // Called at a negedge with the DUT idle; the next edge arbitrates.
  // pert>0: at that DRAW cycle move the winner's data and drop req.
  // keep: 0 drop after ack, 1 hold, 2 random.
  task automatic serve(input bit add, input int pert,
                       input bit rst10, input int keep);
    int   w;
    int   n;
    bit   kp;
    exp_t e;
    if (add)
      for (int i = 0; i < N; i++)
        if (!rq[i] && $urandom_range(0, 2) == 0) new_req(i);
    if (rq == '0) new_req(int'($urandom_range(0, N - 1)));
    w = pick();
    for (int c = 0; c < NPIX; c++) begin
      e.is_ack = 1'b0;
      e.g      = w;
      e.x      = (mx[w] + c / 16) % 256;
      e.y      = (my[w] + c % 16) % 128;
      e.c      = mc[w];
      q.push_back(e);
    end
    e.is_ack = 1'b1;
    e.x = 0;
    e.y = 0;
    e.c = 0;
    q.push_back(e);
    apply();
    for (n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (n == pert) begin
        mx[w] = (mx[w] + 20) % 256;
        my[w] = int'($urandom_range(0, 127));
        mc[w] = int'($urandom_range(0, 7));
        rq[w] = 1'b0;
        apply();
      end
      if (rst10 && n == 10) begin
        resetn = 1'b0;
        @(posedge clock);
        #1;
        q.delete();
        rq = '0;
        apply();
        @(negedge clock);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        ptr_m  = 0;
        resetn = 1'b1;
        return;
      end
      if (bus.ack != '0) break;
    end
    chk("ack_latency", 32'(n), 32'd33);
    if (n > 40) begin
      q.delete();
      return;
    end
    ptr_m = (w + 1) % N;
    kp = (keep == 1) || (keep == 2 && $urandom_range(0, 1) == 1);
    rq[w] = kp;
    apply();
    @(negedge clock);
  endtask

  initial begin
    int w;
    rq = '0;
    for (int i = 0; i < N; i++) begin
      mx[i] = 0;
      my[i] = 0;
      mc[i] = 0;
    end
    apply();
    repeat (3) @(negedge clock);
    chk("reset_plot", 32'(plot), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_grant", 32'(bus.grant), 32'd0);
    chk("reset_ack", 32'(bus.ack), 32'd0);
    chk("reset_xyc", 32'({x_out, y_out, colour_out}), 32'd0);
    resetn = 1'b1;
    @(negedge clock);

    rq[0] = 1'b1;
    mx[0] = 60;
    my[0] = 0;
    mc[0] = 1;
    serve(1'b0, 0, 1'b0, 0);

    rq[2] = 1'b1;
    mx[2] = 255;
    my[2] = 120;
    mc[2] = 5;
    serve(1'b0, 0, 1'b0, 0);

    rq[0] = 1'b1;
    mx[0] = 60;
    my[0] = 0;
    mc[0] = 1;
    serve(1'b0, 5, 1'b0, 0);

    new_req(1);
    new_req(3);
    repeat (4) serve(1'b0, 0, 1'b0, 1);
    rq = '0;
    apply();
    @(negedge clock);

    new_req(1);
    serve(1'b0, 0, 1'b1, 0);
    w = 1;
    rq[w] = 1'b1;
    serve(1'b0, 0, 1'b0, 0);

    for (int r = 0; r < 60; r++)
      serve(1'b1, ($urandom_range(0, 3) == 0) ?
            int'($urandom_range(1, 31)) : 0, 1'b0, 2);

    rq = '0;
    apply();
    repeat (5) @(negedge clock);
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule

// File: doc/sprite_draw_arbiter.md
SPRITE_DRAW_ARBITER -- requirements
Module: sprite_draw_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of sprite datapaths sharing the plot port.
REQ-002 SHALL have parameter SPR_W_LOG2, default 1, meaning log2 of sprite width in pixels (2 wide).
REQ-003 SHALL have parameter SPR_H_LOG2, default 4, meaning log2 of sprite height in pixels (16 tall).
REQ-004 clock  input  1  system clock; all state updates on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 req  input  NUM_REQ  per-requester draw request; held high until matching ack.
REQ-007 req_x  input  8*NUM_REQ  flattened sprite origin x; slice i belongs to requester i.
REQ-008 req_y  input  7*NUM_REQ  flattened sprite origin y.
REQ-009 req_colour  input  3*NUM_REQ  flattened colour (0 = erase/background).
REQ-010 ack  output  NUM_REQ  one-cycle pulse to the served requester when its sprite is fully plotted.
REQ-011 grant  output  NUM_REQ  one-hot; requester currently owning the plot port; zero when idle.
REQ-012 plot  output  1  VGA write enable.
REQ-013 x_out  output  8  pixel x to VGA adapter.
REQ-014 y_out  output  7  pixel y to VGA adapter.
REQ-015 colour_out  output  3  pixel colour to VGA adapter.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, DRAW, DONE.
REQ-018 IDLE: if any req bit high at a rising edge, SHALL select one winner, load one-hot grant, latch that requester's x, y, colour into base registers, clear pixel counter, move to DRAW; else stay IDLE.
REQ-019 DRAW: plot SHALL be 1; x_out = base_x + cnt[SPR_W_LOG2+SPR_H_LOG2-1 : SPR_H_LOG2]; y_out = base_y + cnt[SPR_H_LOG2-1:0]; colour_out = latched colour.
REQ-020 Counter width SHALL be SPR_W_LOG2+SPR_H_LOG2 bits, incrementing each DRAW cycle; on all-ones count SHALL go to DONE (32 plot cycles at defaults).
REQ-021 Coordinate sums SHALL wrap modulo 256 (x) and 128 (y); no clipping.
REQ-022 DONE: ack bit of granted requester SHALL be high for exactly one cycle, plot 0; next state IDLE with grant cleared.
REQ-023 Latency: req seen at edge k -> plot high cycles k..k+31 -> ack cycle k+32 -> IDLE cycle k+33; new arbitration earliest at edge k+33.
REQ-024 Changes to req_x/req_y/req_colour or deassertion of req during DRAW SHALL be ignored; latched transaction completes.
REQ-025 A requester holding req through IDLE after its ack SHALL be treated as a new request.
REQ-026 When idle or in DONE, x_out, y_out, colour_out SHALL be 0.

Reset
REQ-027 resetn low at a rising edge SHALL force IDLE, grant 0, ack 0, plot 0, busy 0, counter 0, base registers 0, round-robin pointer 0, including mid-DRAW (sprite left partially drawn, no ack issued).

Configuration
REQ-028 With ROUND_ROBIN_EN defined, winner SHALL be first requesting index at or after pointer (wrapping); pointer SHALL become winner+1 mod NUM_REQ in DONE.
REQ-029 Without ROUND_ROBIN_EN, winner SHALL be lowest requesting index (fixed priority); no pointer register exists.

Structure
REQ-030 Shared package draw_pkg SHALL hold FSM state encodings, default sprite-dimension constants, and screen widths (X_W=8, Y_W=7, C_W=3).
REQ-031 Winner selection SHALL live in sub-module req_arbiter (inputs req, pointer; output one-hot winner), including the ROUND_ROBIN_EN variant.

Verification
REQ-032 Single req[0], x=60, y=0, colour=1 -> 32 plot cycles covering (60..61, 0..15) column-major, ack[0] at cycle 33 after request edge.
REQ-033 req=4'b1010 held continuously, ROUND_ROBIN_EN -> grants 1,3,1,3; undefined -> grant 1 repeatedly, requester 3 starved.
REQ-034 Origin x=255, y=120 -> x_out values 255 and 0, y_out 120..127 then 0..7.
REQ-035 resetn low at 10th DRAW cycle -> next cycle plot=0, grant=0, busy=0, no ack pulse; later request re-served from counter 0.
REQ-036 req_x changed 60->80 and req[0] dropped mid-DRAW -> all 32 pixels use x=60/61, ack[0] still pulses.
